// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Types and constants shared by the AHB-Lite to APB bridge.
//               Provides the AHB HTRANS encodings, the bridge state enum,
//               the APB slave count and a slave-select one-hot helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

  localparam int NUM_APB_SLV = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

  // One-hot PSEL pattern for a 2-bit slave index.
  function automatic logic [NUM_APB_SLV-1:0] slv_onehot(input logic [1:0] idx);
    slv_onehot = NUM_APB_SLV'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mux.sv
// ============================================================================
// Module      : apb_slave_mux
// Description : Selects the read data, ready and error returns of the APB
//               slave addressed by the registered slave index.
// Ports       : idx         - slave index of the current transfer
//               prdata0..3  - read data from slaves 0..3
//               pready      - ready, bit n from slave n
//               pslverr     - error, bit n from slave n
//               prdata_sel  - read data of the selected slave
//               pready_sel  - ready of the selected slave
//               pslverr_sel - error of the selected slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mux
  import ahb_apb_pkg::*;
(
  input  logic [1:0]             idx,
  input  logic [31:0]            prdata0,
  input  logic [31:0]            prdata1,
  input  logic [31:0]            prdata2,
  input  logic [31:0]            prdata3,
  input  logic [NUM_APB_SLV-1:0] pready,
  input  logic [NUM_APB_SLV-1:0] pslverr,
  output logic [31:0]            prdata_sel,
  output logic                   pready_sel,
  output logic                   pslverr_sel
);

  always_comb begin
    prdata_sel = prdata0;
    case (idx)
      2'd1:    prdata_sel = prdata1;
      2'd2:    prdata_sel = prdata2;
      2'd3:    prdata_sel = prdata3;
      default: prdata_sel = prdata0;
    endcase
  end

  assign pready_sel  = pready[idx];
  assign pslverr_sel = pslverr[idx];

endmodule

`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
// ============================================================================
// Module      : ahb2apb_bridge
// Description : AHB-Lite slave to APB master bridge for four APB slaves.
//               One transfer at a time; the slave is chosen by the 2-bit
//               HADDR field starting at SEL_LSB. Writes spend one extra
//               cycle capturing HWDATA before the APB setup phase.
//               Build option APB_WAIT_ERR_EN: honour PREADY wait states and
//               turn PSLVERR into a two-cycle AHB ERROR response. Without it
//               the APB access phase is always one cycle and HRESP stays 0.
// Ports       : HCLK, HRESET (async, active high)
//               AHB-Lite slave : HSEL, HADDR, HTRANS, HWRITE, HSIZE (unused),
//                                HREADY, HWDATA, HREADYOUT, HRDATA, HRESP
//               APB master     : PADDR, PWRITE, PWDATA, PENABLE, PSEL[3:0],
//                                PRDATA0..3, PREADY[3:0], PSLVERR[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int SEL_LSB = 12
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic                   HREADY,
  input  logic [31:0]            HWDATA,
  output logic                   HREADYOUT,
  output logic [31:0]            HRDATA,
  output logic                   HRESP,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [NUM_APB_SLV-1:0] PSEL,
  input  logic [31:0]            PRDATA0,
  input  logic [31:0]            PRDATA1,
  input  logic [31:0]            PRDATA2,
  input  logic [31:0]            PRDATA3,
  input  logic [NUM_APB_SLV-1:0] PREADY,
  input  logic [NUM_APB_SLV-1:0] PSLVERR
);

  bridge_state_t state, state_next;

  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  idx_q;
  logic [31:0] pwdata_q;
  logic [31:0] hrdata_q;

  logic        trans_active;
  logic        accept;
  logic        complete;
  logic        slv_err;
  logic [31:0] prdata_sel;
  logic        pready_sel;
  logic        pslverr_sel;
  logic        unused_inputs;

  always_comb begin
    trans_active = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default:                   trans_active = 1'b0;
    endcase
  end

  // Address phase is only taken while the bridge is idle; any address
  // presented during a data phase is dropped.
  assign accept = HSEL & trans_active & HREADY & (state == ST_IDLE);

  apb_slave_mux u_mux (
    .idx         (idx_q),
    .prdata0     (PRDATA0),
    .prdata1     (PRDATA1),
    .prdata2     (PRDATA2),
    .prdata3     (PRDATA3),
    .pready      (PREADY),
    .pslverr     (PSLVERR),
    .prdata_sel  (prdata_sel),
    .pready_sel  (pready_sel),
    .pslverr_sel (pslverr_sel)
  );

`ifdef APB_WAIT_ERR_EN
  assign complete      = pready_sel;
  assign slv_err       = pslverr_sel;
  assign unused_inputs = ^HSIZE;
`else
  assign complete      = 1'b1;
  assign slv_err       = 1'b0;
  assign unused_inputs = ^{HSIZE, pready_sel, pslverr_sel};
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    PSEL       = '0;
    PENABLE    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = HWRITE ? ST_WDATA : ST_SETUP;
        end
      end
      ST_WDATA: begin
        HREADYOUT  = 1'b0;
        state_next = ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT  = 1'b0;
        PSEL       = slv_onehot(idx_q);
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        PSEL      = slv_onehot(idx_q);
        PENABLE   = 1'b1;
        if (complete) begin
          state_next = slv_err ? ST_ERR1 : ST_IDLE;
        end
      end
      // AHB ERROR needs HRESP high for two cycles, the first with
      // HREADYOUT low so the master can cancel its next address phase.
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        idx_q   <= HADDR[SEL_LSB+1:SEL_LSB];
      end
      // HWDATA is valid in the cycle after the write address phase.
      if (state == ST_WDATA) begin
        pwdata_q <= HWDATA;
      end
      if ((state == ST_ACCESS) && complete && !write_q && !slv_err) begin
        hrdata_q <= prdata_sel;
      end
    end
  end

  assign PADDR  = addr_q;
  assign PWRITE = write_q;
  assign PWDATA = pwdata_q;
  assign HRDATA = hrdata_q;

endmodule

`default_nettype wire
